// File: rtl/md_seq_ctrl.sv
// md_seq_ctrl: sequencer between the ID/EX pipeline and the HI/LO multiply/divide unit.
// Accepts MULT/DIV/MFHI/MFLO/MTHI/MTLO, launches and times unit operations, stalls the
// pipeline while busy, returns HI/LO read data and flags divide-by-zero and timeout.
// Ports:
//   clk, reset (async, active-low)
//   op_valid/op_code/op_a/op_b/op_ready/flush/stall : pipeline op handshake
//   busy                                            : sequencer not idle
//   rd_data/rd_valid                                : MFHI/MFLO result
//   dz_err/to_err                                   : divide-by-zero / unit timeout pulses
//   md_reset/md_start/md_selmd/md_selhl/md_write    : unit control
//   md_da/md_db                                     : held unit operands
//   md_flag/md_dc                                   : unit done flag / read data
module md_seq_ctrl #(
  parameter int unsigned MUL_LAT   = 4,
  parameter int unsigned DIV_LAT   = 32,
  parameter int unsigned TIMEOUT   = 64,
  parameter bit          DIVZ_TRAP = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        op_ready,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        dz_err,
  output logic        to_err,
  output logic        md_reset,
  output logic        md_start,
  output logic        md_selmd,
  output logic        md_selhl,
  output logic        md_write,
  output logic [31:0] md_da,
  output logic [31:0] md_db,
  input  logic        md_flag,
  input  logic [31:0] md_dc
);

  localparam int unsigned CMAX = (DIV_LAT > TIMEOUT) ? DIV_LAT : TIMEOUT;
  localparam int unsigned CW   = $clog2(CMAX) + 1;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_START, S_WAIT, S_WRITE, S_READ
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP, OP_MULT, OP_DIV, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO, OP_RSVD
  } op_t;

  state_t        state, state_n;
  op_t           op;
  logic [CW-1:0] cnt, cnt_n;
  logic          tmo, tmo_n;
  logic          accept;
  logic          reset_n, start_n, write_n, rdv_n, dz_n, to_n;
  logic          selmd_n, selhl_n;
  logic [31:0]   rdata_n, da_n, db_n;

  assign op     = op_t'(op_code);
  assign accept = op_valid & op_ready & ~flush;
  assign stall  = op_valid & ~op_ready;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    tmo_n   = tmo;
    reset_n = 1'b0;
    start_n = 1'b0;
    write_n = 1'b0;
    rdv_n   = 1'b0;
    dz_n    = 1'b0;
    to_n    = 1'b0;
    selmd_n = md_selmd;
    selhl_n = md_selhl;
    rdata_n = rd_data;
    da_n    = md_da;
    db_n    = md_db;
    case (state)
      S_INIT: begin
        if (cnt == '0) begin
          state_n = S_IDLE;
        end else begin
          reset_n = 1'b1;
          cnt_n   = cnt - CW'(1);
        end
      end
      S_IDLE: begin
        if (accept) begin
          case (op)
            OP_MULT, OP_DIV: begin
              if (op == OP_DIV && DIVZ_TRAP && op_b == '0) begin
                dz_n = 1'b1;
              end else begin
                da_n    = op_a;
                db_n    = op_b;
                selmd_n = (op == OP_DIV);
                cnt_n   = (op == OP_DIV) ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
                tmo_n   = 1'b0;
                state_n = S_START;
              end
            end
            OP_MFHI, OP_MFLO: begin
              da_n    = op_a;
              db_n    = op_b;
              selhl_n = (op == OP_MFHI);
              state_n = S_READ;
            end
            OP_MTHI, OP_MTLO: begin
              da_n    = op_a;
              db_n    = op_b;
              selhl_n = (op == OP_MTHI);
              state_n = S_WRITE;
            end
            default: ;
          endcase
        end
      end
      // md_start is registered on leaving START so a flush seen in START can still cancel it.
      S_START: begin
        cnt_n = cnt - CW'(1);
        if (flush) begin
          state_n = S_IDLE;
        end else begin
          start_n = 1'b1;
          state_n = S_WAIT;
        end
      end
      // Latency phase ignores md_flag; once it expires, cnt is reloaded for the timeout phase.
      S_WAIT: begin
        if (!tmo) begin
          if (cnt != '0) begin
            cnt_n = cnt - CW'(1);
          end else if (md_flag) begin
            state_n = S_IDLE;
          end else begin
            tmo_n = 1'b1;
            cnt_n = CW'(TIMEOUT);
          end
        end else begin
          if (md_flag) begin
            state_n = S_IDLE;
          end else if (cnt == '0) begin
            to_n    = 1'b1;
            state_n = S_IDLE;
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
      end
      S_WRITE: begin
        write_n = ~flush;
        state_n = S_IDLE;
      end
      S_READ: begin
        if (flush) begin
          state_n = S_IDLE;
        end else if (md_flag) begin
          rdata_n = md_dc;
          rdv_n   = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_INIT;
      cnt      <= CW'(1);
      tmo      <= 1'b0;
      op_ready <= 1'b0;
      busy     <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      dz_err   <= 1'b0;
      to_err   <= 1'b0;
      md_reset <= 1'b1;
      md_start <= 1'b0;
      md_selmd <= 1'b0;
      md_selhl <= 1'b0;
      md_write <= 1'b0;
      md_da    <= '0;
      md_db    <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      tmo      <= tmo_n;
      op_ready <= (state_n == S_IDLE);
      busy     <= (state_n != S_IDLE);
      rd_data  <= rdata_n;
      rd_valid <= rdv_n;
      dz_err   <= dz_n;
      to_err   <= to_n;
      md_reset <= reset_n;
      md_start <= start_n;
      md_selmd <= selmd_n;
      md_selhl <= selhl_n;
      md_write <= write_n;
      md_da    <= da_n;
      md_db    <= db_n;
    end
  end

endmodule
